// File: rtl/operand_fetch_pkg.sv
// Shared types for operand fetch: architectural state and decoded bundle.
// Field helpers slice RV32 I-type/R-type words.
package operand_fetch_pkg;

    localparam int OF_MEM_AW = 10;
    localparam int OF_XLEN   = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [OF_XLEN-1:0]                pc;
        logic [31:0][OF_XLEN-1:0]          x;
        logic [2**OF_MEM_AW-1:0][31:0]     mem;
        logic                              intr_en;
    } REGISTERS;

    typedef struct packed {
        logic [OF_XLEN-1:0] pc;
        logic [31:0]        instr;
        logic [4:0]         rd;
        logic [OF_XLEN-1:0] rs1_val;
        logic [OF_XLEN-1:0] rs2_val;
        logic [OF_XLEN-1:0] imm_i;
        logic               trap;
        logic               misalign;
    } DECODE;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        READ,
        HOLD
    } FETCH_STATE;

    function automatic logic [4:0] f_rs1(input logic [31:0] w);
        return w[19:15];
    endfunction

    function automatic logic [4:0] f_rs2(input logic [31:0] w);
        return w[24:20];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] w);
        return w[11:7];
    endfunction

    function automatic logic [OF_XLEN-1:0] f_imm_i(input logic [31:0] w);
        return {{(OF_XLEN-12){w[31]}}, w[31:20]};
    endfunction

endpackage

// File: rtl/operand_fetch.sv
// Operand fetch: IDLE->FETCH->READ->HOLD, one decoded instruction per step.
// Ports: clk, reset, regs, step, irq in; dec, dec_valid, busy out; dec_ready in.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int          MEM_AW   = OF_MEM_AW,
    parameter int          XLEN     = OF_XLEN,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0010
) (
    input  logic     clk,
    input  logic     reset,
    input  REGISTERS regs,
    input  logic     step,
    input  logic     irq,
    output DECODE    dec,
    output logic     dec_valid,
    input  logic     dec_ready,
    output logic     busy
);

    FETCH_STATE       state_q;
    logic [XLEN-1:0]  pc_q;
    logic [31:0]      instr_q;
    logic             trap_q;
    logic             misalign_q;
    DECODE            dec_q;
    logic             dec_valid_q;
    logic             busy_q;

    logic [31:0]      fetch_word;
    logic             trap_now;
    logic             mis_now;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    DECODE            dec_d;

    always_comb begin
        // Only the word-index bits of pc address memory; upper bits wrap.
        fetch_word = regs.mem[pc_q[MEM_AW+1:2]];
        trap_now   = regs.intr_en & irq;
        // A taken trap suppresses the misalign report.
        mis_now    = ~trap_now & (pc_q[1:0] != 2'b00);
        rs1        = f_rs1(instr_q);
        rs2        = f_rs2(instr_q);
        dec_d          = '0;
        dec_d.pc       = trap_q ? XLEN'(TRAP_VEC) : pc_q;
        dec_d.instr    = instr_q;
        dec_d.rd       = f_rd(instr_q);
        dec_d.rs1_val  = (rs1 == 5'd0) ? '0 : regs.x[rs1];
        dec_d.rs2_val  = (rs2 == 5'd0) ? '0 : regs.x[rs2];
        dec_d.imm_i    = f_imm_i(instr_q);
        dec_d.trap     = trap_q;
        dec_d.misalign = misalign_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            instr_q     <= '0;
            trap_q      <= 1'b0;
            misalign_q  <= 1'b0;
            dec_q       <= '0;
            dec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (step) begin
                        pc_q    <= regs.pc;
                        state_q <= FETCH;
                        busy_q  <= 1'b1;
                    end
                end
                FETCH: begin
                    trap_q     <= trap_now;
                    misalign_q <= mis_now;
                    instr_q    <= (trap_now | mis_now) ? NOP_INSTR
                                                       : fetch_word;
                    state_q    <= READ;
                end
                READ: begin
                    dec_q       <= dec_d;
                    dec_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (dec_ready) begin
                        dec_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dec       = dec_q;
    assign dec_valid = dec_valid_q;
    assign busy      = busy_q;

endmodule
